// File: rtl/frame_payload_buffer.sv
// frame_payload_buffer: checks and strips the 2-byte header of aligned
// 12-byte frames and queues payload speculatively in a byte FIFO.
module frame_payload_buffer #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       frame_detect,
    input  logic [3:0] fr_byte_position,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_hdr_type,
    output logic [7:0] drop_cnt,
    output logic [7:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] CAP = PW'(DEPTH);

    typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DISCARD} state_t;

    state_t        state, state_n;
    logic [PW-1:0] rd, wr_c, wr_s, wr_c_n, wr_s_n, free;
    logic [10:0]   mem [DEPTH];
    logic [10:0]   head, wdata;
    logic [7:0]    h0;
    logic [3:0]    pos, pos_q, pos_n;
    logic          type_q, type_n;
    logic          h0_ld, we, brk, err_inc, drop_inc, pop, hdr_ok;

    assign pos       = fr_byte_position;
    assign out_valid = (wr_c != rd);
    assign pop       = out_valid && out_ready;
    assign free      = CAP - (wr_c - rd);
    assign hdr_ok    = ({h0, rx_data} == 16'hAAAF) || ({h0, rx_data} == 16'h55BA);
    assign wdata     = {type_q, pos == 4'd11, pos == 4'd2, rx_data};

    // Head is masked while empty so stale memory never leaks out.
    assign head = out_valid ? mem[rd[AW-1:0]] : '0;
    assign {out_hdr_type, out_eof, out_sof, out_data} = head;

    always_comb begin
        state_n  = state;
        wr_c_n   = wr_c;
        wr_s_n   = wr_s;
        pos_n    = pos_q;
        type_n   = type_q;
        h0_ld    = 1'b0;
        we       = 1'b0;
        brk      = 1'b0;
        err_inc  = 1'b0;
        drop_inc = 1'b0;
        if (!frame_detect) begin
            state_n = IDLE;
            if (state == HDR1 || state == PAYLOAD) begin
                wr_s_n  = wr_c;
                err_inc = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (pos == 4'd0) begin
                        state_n = HDR1;
                        h0_ld   = 1'b1;
                    end
                end
                HDR1: begin
                    if (pos != 4'd1) begin
                        brk = 1'b1;
                    end else if (!hdr_ok) begin
                        state_n = DISCARD;
                        err_inc = 1'b1;
                    end else if (free >= PW'(10)) begin
                        state_n = PAYLOAD;
                        pos_n   = 4'd1;
                        type_n  = (h0 == 8'h55);
                    end else begin
                        state_n  = DISCARD;
                        drop_inc = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (pos != pos_q + 4'd1) begin
                        brk = 1'b1;
                    end else begin
                        we     = 1'b1;
                        pos_n  = pos;
                        wr_s_n = wr_s + PW'(1);
                        if (pos == 4'd11) begin
                            wr_c_n  = wr_s + PW'(1);
                            state_n = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (pos == 4'd11) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            // A stray pos 0 restarts a frame immediately.
            if (brk) begin
                wr_s_n  = wr_c;
                err_inc = 1'b1;
                if (pos == 4'd0) begin
                    state_n = HDR1;
                    h0_ld   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd       <= '0;
            wr_c     <= '0;
            wr_s     <= '0;
            h0       <= '0;
            pos_q    <= '0;
            type_q   <= 1'b0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state  <= state_n;
            wr_c   <= wr_c_n;
            wr_s   <= wr_s_n;
            pos_q  <= pos_n;
            type_q <= type_n;
            if (pop) rd <= rd + PW'(1);
            if (h0_ld) h0 <= rx_data;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_s[AW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_frame_payload_buffer.sv
// tb_frame_payload_buffer: randomized frame traffic against a queue-based
// reference model, plus directed frame scenarios with literal expectations.
module tb_frame_payload_buffer;
    localparam int DEPTH = 32;
    localparam int M_IDLE = 0, M_HDR = 1, M_PAY = 2, M_DISC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       frame_detect = 1'b0;
    logic [3:0] fr_byte_position = '0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data, drop_cnt, err_cnt;
    logic       out_valid, out_sof, out_eof, out_hdr_type;

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;

    frame_payload_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .frame_detect(frame_detect), .fr_byte_position(fr_byte_position),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .out_hdr_type(out_hdr_type),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed queue (what the consumer will see),
    // pending queue (current frame's payload), and frame-level mode.
    logic [10:0] cq[$];
    logic [10:0] pq[$];
    int          m_mode = M_IDLE;
    int          m_prev = 0;
    logic [7:0]  m_h0 = '0;
    logic        m_type = 1'b0;
    int          m_err = 0;
    int          m_drop = 0;

    always @(posedge clk or posedge rst) begin
        int n, p;
        bit commit, brk;
        if (rst) begin
            cq.delete();
            pq.delete();
            m_mode = M_IDLE;
            m_err = 0;
            m_drop = 0;
        end else begin
            n = cq.size();
            p = int'(fr_byte_position);
            commit = 0;
            brk = 0;
            if (!frame_detect) begin
                if (m_mode == M_HDR || m_mode == M_PAY) begin
                    pq.delete();
                    if (m_err < 255) m_err++;
                end
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: if (p == 0) begin
                        m_h0 = rx_data;
                        m_mode = M_HDR;
                    end
                    M_HDR: begin
                        if (p != 1) brk = 1;
                        else if ((m_h0 == 8'hAA && rx_data == 8'hAF) ||
                                 (m_h0 == 8'h55 && rx_data == 8'hBA)) begin
                            if (DEPTH - n >= 10) begin
                                m_mode = M_PAY;
                                m_prev = 1;
                                m_type = (m_h0 == 8'h55);
                            end else begin
                                m_mode = M_DISC;
                                if (m_drop < 255) m_drop++;
                            end
                        end else begin
                            m_mode = M_DISC;
                            if (m_err < 255) m_err++;
                        end
                    end
                    M_PAY: begin
                        if (p != m_prev + 1) brk = 1;
                        else begin
                            pq.push_back({m_type, p == 11, p == 2, rx_data});
                            m_prev = p;
                            if (p == 11) begin
                                commit = 1;
                                m_mode = M_IDLE;
                            end
                        end
                    end
                    default: if (p == 11) m_mode = M_IDLE;
                endcase
                if (brk) begin
                    pq.delete();
                    if (m_err < 255) m_err++;
                    if (p == 0) begin
                        m_h0 = rx_data;
                        m_mode = M_HDR;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            if (n > 0 && out_ready) void'(cq.pop_front());
            if (commit) begin
                foreach (pq[i]) cq.push_back(pq[i]);
                pq.delete();
            end
        end
    end

    always @(negedge clk) begin
        logic [10:0] exp;
        if (cq.size() > 0) exp = cq[0];
        else exp = '0;
        check("valid", out_valid, cq.size() > 0);
        check("head", {out_hdr_type, out_eof, out_sof, out_data}, exp);
        check("drop_cnt", drop_cnt, m_drop);
        check("err_cnt", err_cnt, m_err);
    end

    task automatic send(input bit fd, input int p, input logic [7:0] d);
        frame_detect = fd;
        fr_byte_position = 4'(p);
        rx_data = d;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] base, input int stop, input bit cut);
        for (int p = 0; p < 12; p++) begin
            if (p == stop) begin
                if (cut) send(0, p, 8'h00);
                return;
            end
            send(1, p, (p == 0) ? a : (p == 1) ? b : 8'(int'(base) + p - 2));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            send(0, $urandom_range(0, 11), 8'($urandom));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_flags", {out_sof, out_eof, out_hdr_type}, 0);
        rst = 1'b0;

        // Clean frame
        rdy_pct = 100;
        frame(8'hAA, 8'hAF, 8'h01, 12, 0);
        frame_detect = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("clean_valid", out_valid, 1);
            check("clean_data", out_data, i + 1);
            check("clean_sof", out_sof, i == 0);
            check("clean_eof", out_eof, i == 9);
            check("clean_type", out_hdr_type, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("clean_empty", out_valid, 0);
        check("clean_cnts", {drop_cnt, err_cnt}, 0);
        @(posedge clk);
        #1;

        // Bad header then type-1 frame
        frame(8'h55, 8'hBB, 8'h20, 12, 0);
        idle(2);
        check("badhdr_err", err_cnt, 1);
        check("badhdr_empty", out_valid, 0);
        frame(8'h55, 8'hBA, 8'h30, 12, 0);
        frame_detect = 1'b0;
        @(negedge clk);
        check("type1_head", {out_valid, out_hdr_type, out_sof, out_data}, {3'b111, 8'h30});
        @(posedge clk);
        #1;
        idle(12);

        // Lock loss at pos 6
        frame(8'hAA, 8'hAF, 8'h40, 6, 1);
        idle(2);
        check("lock_err", err_cnt, 2);
        check("lock_empty", out_valid, 0);
        frame(8'hAA, 8'hAF, 8'h50, 12, 0);
        idle(12);

        // Back-pressure and full
        rdy_pct = 0;
        for (int f = 0; f < 4; f++) frame(8'hAA, 8'hAF, 8'(8'h60 + 16 * f), 12, 0);
        idle(1);
        check("bp_drop", drop_cnt, 1);
        check("bp_model_fill", cq.size(), 30);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            frame_detect = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) n++;
            @(posedge clk);
            #1;
        end
        check("bp_popped", n, 30);
        check("bp_empty", out_valid, 0);
        rdy_pct = 100;

        // Sequence break: pos 5 then pos 0
        frame(8'hAA, 8'hAF, 8'hA0, 6, 0);
        frame(8'h55, 8'hBA, 8'hC0, 12, 0);
        frame_detect = 1'b0;
        @(negedge clk);
        check("seq_err", err_cnt, 3);
        check("seq_head", {out_valid, out_sof, out_data}, {2'b11, 8'hC0});
        @(posedge clk);
        #1;
        idle(12);

        // Async reset mid-frame with 20 bytes stored
        rdy_pct = 0;
        frame(8'hAA, 8'hAF, 8'h10, 12, 0);
        frame(8'hAA, 8'hAF, 8'h20, 12, 0);
        frame(8'hAA, 8'hAF, 8'h30, 5, 0);
        check("pre_rst_fill", cq.size(), 20);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_cnts", {drop_cnt, err_cnt}, 0);
        rst = 1'b0;
        rdy_pct = 100;
        frame(8'hAA, 8'hAF, 8'hD0, 12, 0);
        frame_detect = 1'b0;
        @(negedge clk);
        check("post_rst_head", {out_valid, out_sof, out_data}, {2'b11, 8'hD0});
        @(posedge clk);
        #1;
        idle(12);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int kind, at;
            logic [7:0] base;
            case ((k / 50) % 4)
                0: rdy_pct = 100;
                1: rdy_pct = 60;
                2: rdy_pct = 20;
                default: rdy_pct = 0;
            endcase
            kind = $urandom_range(0, 9);
            at = $urandom_range(1, 11);
            base = 8'($urandom);
            case (kind)
                0, 1, 2, 3: frame(8'hAA, 8'hAF, base, 12, 0);
                4, 5: frame(8'h55, 8'hBA, base, 12, 0);
                6: frame(8'h55, 8'($urandom_range(0, 1) ? 8'hAF : 8'h33), base, 12, 0);
                7: frame(8'hAA, 8'hAF, base, at, 1);
                8: frame(8'h55, 8'hBA, base, at, 0);
                default: send(1, $urandom_range(1, 11), base);
            endcase
            if (kind != 8) idle($urandom_range(0, 2));
        end
        rdy_pct = 100;
        idle(40);
        check("rand_drained", out_valid, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send(1, 0, 8'h55);
            send(1, 1, 8'h00);
            send(0, 0, 8'h00);
        end
        check("err_sat", err_cnt, 255);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_payload_buffer.md
# frame_payload_buffer

Downstream consumer of the frame aligner. While the aligner reports lock, it takes the aligned byte stream (`rx_data`, `frame_detect`, `fr_byte_position`), checks each 12-byte frame's 2-byte header, and strips it. The 10 payload bytes of each good frame go into a byte FIFO and are released on a valid/ready stream with frame markers. Frames are written speculatively, so incomplete or bad frames are rolled back and never appear at the output.

## Interface
- `DEPTH`, 32, FIFO depth in bytes; power of 2, ≥ 16.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: aligned byte stream from the aligner.
- `frame_detect` input 1: aligner lock; bytes are accepted only while high.
- `fr_byte_position` input 4: position of `rx_data` in the frame, 0..11. Header is at 0..1, payload at 2..11.
- `out_data` output 8: payload byte at the FIFO head.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry.
- `out_sof` output 1: head is payload byte 0 of its frame.
- `out_eof` output 1: head is payload byte 9 of its frame.
- `out_hdr_type` output 1: frame header type; 0 = AA AF, 1 = 55 BA.
- `drop_cnt` output 8: frames dropped for lack of space; saturates at 255.
- `err_cnt` output 8: frames discarded for bad header or sequence break; saturates at 255.

## Operation
- FIFO entry is 11 bits: {hdr_type, eof, sof, data}.
- Pointers are log2(DEPTH)+1 bits wide:
  - `rd`: read pointer.
  - `wr_c`: committed write pointer.
  - `wr_s`: speculative write pointer.
- `out_valid` = (`wr_c` != `rd`). The FIFO is first-word-fall-through: `out_*` is a combinational read at `rd`.
- A pop occurs when `out_valid` && `out_ready`; `rd` then increments.
- FSM states: IDLE, HDR1, PAYLOAD, DISCARD. In every state, `frame_detect`=0 forces IDLE.
- IDLE:
  - Moves to HDR1 when `frame_detect` && pos==0. It latches `rx_data` as h0.
  - Any other position is ignored.
- HDR1:
  - Requires pos==1.
  - Header {h0, `rx_data`} of AA AF gives type 0; 55 BA gives type 1; anything else goes to DISCARD with `err_cnt`+1.
  - On a good header, free = DEPTH − (`wr_c` − `rd`) is checked in the same cycle. If free ≥ 10, go to PAYLOAD. Otherwise go to DISCARD with `drop_cnt`+1.
- PAYLOAD:
  - Requires pos == previous+1. Each byte is written at `wr_s`, and `wr_s` increments.
  - sof is set at pos 2; eof is set at pos 11.
  - At pos 11, `wr_c` ← `wr_s`+1 (commit) and the FSM returns to IDLE.
- DISCARD: waits for pos 11 or `frame_detect`=0, then goes to IDLE. Nothing is written.
- Sequence break: an unexpected pos while in HDR1 or PAYLOAD.
  - Roll back: `wr_s` ← `wr_c`.
  - `err_cnt`+1.
  - If the offending pos==0, go directly to HDR1 and latch h0. Otherwise go to IDLE.
- `frame_detect` falling in HDR1 or PAYLOAD: roll back, `err_cnt`+1, go to IDLE.
- A pop during a frame write is always legal. Free space only grows, so the admission check at pos 1 guarantees no overflow.
- Counters saturate; they never wrap.

## Timing
- Reset values:
  - `rd`, `wr_c`, `wr_s` = 0.
  - FSM = IDLE.
  - `out_valid`, `out_sof`, `out_eof`, `out_hdr_type` = 0; `out_data` = 0 (memory output masked while empty).
  - `drop_cnt`, `err_cnt` = 0.
- Reset clears all committed and in-flight data immediately (asynchronous).
- Write latency:
  - The pos-11 byte is sampled at edge N, and commit happens at edge N.
  - With the FIFO previously empty, `out_valid`=1 with `out_sof`=1 holding payload byte 0 in the cycle after edge N.
- Commit and pop in the same edge: both pointers update, and count = old + 10 − 1.
- Rollback and pop in the same edge: `rd` still advances; `wr_s` takes the old `wr_c`.
- With `out_ready` held high, one byte pops per cycle.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.
- Full boundary: committed count DEPTH−9 or more at pos 1 drops the frame. Exactly DEPTH−10 admits it, and the FIFO ends completely full.
- Pointer wrap is modulo 2·DEPTH; full/empty is distinguished by the MSB.

## Test plan
- Clean frame: AA AF then 01..0A at pos 0..11 with `frame_detect`=1, `out_ready`=1 → `out_data` 01..0A on 10 consecutive cycles starting the cycle after pos 11. `out_sof` is on 01, `out_eof` on 0A, `out_hdr_type`=0. Both counters stay 0.
- Bad header: 55 BB then payload → no output, `err_cnt`=1. The following 55 BA frame is output with `out_hdr_type`=1.
- Lock loss: `frame_detect` drops at pos 6 → `wr_s` returns to `wr_c`, nothing is output, `err_cnt`=1. The next full frame is output intact.
- Back-pressure and full: `out_ready`=0 for 4 frames with DEPTH=32 → frames 1–3 are stored (30 bytes) and frame 4 is dropped (`drop_cnt`=1). Releasing `out_ready` yields exactly 30 bytes in order, then `out_valid`=0.
- Sequence break: pos jumps from 5 to 0 mid-payload → rollback, `err_cnt`+1, and the new frame starting at that pos 0 is accepted.
- Async reset: `rst` pulsed mid-frame with 20 bytes stored → `out_valid`=0 immediately and counters are 0. The next frame is output normally.
